pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter N, default 20, counter/compare width in bits.
REQ-002 Parameter CH, default 4, number of PWM output channels.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  run counter when 1; hold idle when 0.
REQ-006 cfg_valid  input  1  new configuration offered.
REQ-007 cfg_ready  output  1  configuration slot free; handshake completes when cfg_valid && cfg_ready.
REQ-008 cfg_full_cycle  input  N  last counter value of the period.
REQ-009 cfg_duty  input  CH*N  per-channel duty; channel k at bits [k*N +: N].
REQ-010 cfg_mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 pwm_out  output  CH  PWM pulses, bit k = channel k.
REQ-012 period_start  output  1  one-cycle pulse on the first cycle of every period.

Function
REQ-013 Active registers (full_cycle, duty[CH], mode) SHALL drive generation; a shadow/pending register SHALL hold one accepted configuration.
REQ-014 Handshake SHALL load the shadow and set pending on the next edge; cfg_ready SHALL equal !pending.
REQ-015 Edge mode: counter SHALL count 0..full_cycle, then wrap to 0; period = full_cycle+1 cycles.
REQ-016 Center mode: counter SHALL count up 0..full_cycle, then down to 0, without repeating 0 or full_cycle; period = 2*full_cycle cycles.
REQ-017 In center mode, full_cycle==0 SHALL hold the counter at 0 with a period of 1 cycle.
REQ-018 pwm_out[k] SHALL be (counter < duty[k]) while enable=1, combinational from registers (zero added latency).
REQ-019 duty==0 SHALL give a constant low output; duty > full_cycle SHALL give a constant high output.
REQ-020 The period-end cycle SHALL be the cycle whose next counter value starts a new period (edge: counter==full_cycle; center: counting down with counter==1, or full_cycle<=1 at the turnaround).
REQ-021 At the period-end cycle, if pending was set at the start of that cycle, the shadow SHALL copy into the active registers and pending SHALL clear; the new configuration SHALL take effect on the next period's first cycle.
REQ-022 A handshake during a period-end cycle SHALL apply at the following period end, not the current one.
REQ-023 period_start SHALL be 1 when enable=1 and the counter is 0 at the start of a period.
REQ-024 enable=0 SHALL hold the counter at 0 and the direction at up, force pwm_out=0 and period_start=0, and apply pending on the next edge.
REQ-025 On the rising edge of enable, generation SHALL start at counter 0 counting up, with period_start=1 in the first enabled cycle.
REQ-026 All arithmetic SHALL be unsigned N-bit; the counter SHALL never exceed full_cycle.

Reset
REQ-027 reset_n=0 SHALL immediately clear the counter, direction (up), active and shadow registers, and pending; pwm_out=0, period_start=0, cfg_ready=1.
REQ-028 A reset mid-period SHALL discard any pending configuration.

Configuration
REQ-029 Macro PWM_CENTER_EN defined: cfg_mode SHALL be honoured as in REQ-016/017.
REQ-030 Macro PWM_CENTER_EN undefined: cfg_mode SHALL be ignored, mode SHALL be edge only, and no direction or mode registers SHALL exist.

Structure
REQ-031 Package pwm_pkg SHALL hold the enum pwm_mode_e {PWM_EDGE, PWM_CENTER} and the default N/CH constants.
REQ-032 Sub-module pwm_timebase SHALL own the counter, direction, period-end and period_start logic; pwm_bank SHALL own the shadow/active registers and the CH comparators.

Verification (N=8, CH=2)
REQ-033 Reset release, enable=1, config full=9, duty={3,0}, edge -> ch0 high 3 of every 10 cycles; ch1 always 0; period_start every 10 cycles.
REQ-034 Duty 3->7 accepted at counter=4 -> current period keeps 3 high cycles; next period has 7; cfg_ready=0 until the period-end cycle has passed.
REQ-035 duty=12, full=9 -> ch0 constant 1; full=0, duty=1 -> constant 1 with period_start every cycle.
REQ-036 Center mode, full=4, duty=2 -> counter sequence 0,1,2,3,4,3,2,1 repeats; ch0 high 3 of 8 cycles.
REQ-037 reset_n pulsed mid-period with pending set -> pwm_out=0 immediately, cfg_ready=1, old configuration discarded (active duty=0).
REQ-038 enable=0, then a configuration handshake -> pwm_out=0, and the configuration is active on the next edge; after enable=1, period_start=1 on the first cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM bank.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_N_DEFAULT  = 20;
    localparam int PWM_CH_DEFAULT = 4;

endpackage

// File: rtl/pwm_timebase.sv
// Period counter for the PWM bank: edge or center-aligned counting, period-end and period_start.
// Center-aligned counting and the direction flop exist only when PWM_CENTER_EN is defined.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [N-1:0] full_cycle,
`ifdef PWM_CENTER_EN
    input  pwm_mode_e    mode,
`endif
    output logic [N-1:0] count,
    output logic         period_end,
    output logic         period_start
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] count_q, count_d;
`ifdef PWM_CENTER_EN
    logic down_q, down_d;
`endif

    // Defaults leave the counter at 0 counting up, which is also the idle state.
    always_comb begin
        count_d    = '0;
        period_end = 1'b0;
`ifdef PWM_CENTER_EN
        down_d     = 1'b0;
        if (enable) begin
            if (mode == PWM_CENTER) begin
                if (!down_q) begin
                    if (count_q >= full_cycle) begin
                        if (full_cycle <= ONE) begin
                            period_end = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                            down_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else if (count_q <= ONE) begin
                    period_end = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                    down_d  = 1'b1;
                end
            end else if (count_q >= full_cycle) begin
                period_end = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
`else
        if (enable) begin
            if (count_q >= full_cycle) begin
                period_end = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
`ifdef PWM_CENTER_EN
            down_q  <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
`ifdef PWM_CENTER_EN
            down_q  <= down_d;
`endif
        end
    end

    // Zero is only ever visited at the start of a period, in both modes.
    assign count        = count_q;
    assign period_start = reset_n && enable && (count_q == '0);

endmodule

// File: rtl/pwm_bank.sv
// Bank of CH PWM comparators on a shared timebase, with a one-deep shadow config applied at period ends.
// Defining PWM_CENTER_EN enables center-aligned mode via cfg_mode; otherwise cfg_mode is ignored.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int N  = PWM_N_DEFAULT,
    parameter int CH = PWM_CH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [N-1:0]    cfg_full_cycle,
    input  logic [CH*N-1:0] cfg_duty,
    input  logic            cfg_mode,
    output logic [CH-1:0]   pwm_out,
    output logic            period_start
);

    logic [N-1:0]         active_full_q, active_full_d;
    logic [N-1:0]         shadow_full_q, shadow_full_d;
    logic [CH-1:0][N-1:0] active_duty_q, active_duty_d;
    logic [CH-1:0][N-1:0] shadow_duty_q, shadow_duty_d;
    logic                 pending_q, pending_d;
    logic [N-1:0]         count;
    logic                 period_end;
    logic                 handshake;
    logic                 apply;
`ifdef PWM_CENTER_EN
    pwm_mode_e            active_mode_q, active_mode_d;
    pwm_mode_e            shadow_mode_q, shadow_mode_d;
`else
    logic                 unused_cfg_mode;
    assign unused_cfg_mode = cfg_mode;
`endif

    assign cfg_ready = !pending_q;
    assign handshake = cfg_valid && !pending_q;
    // A pending config lands at a period boundary, or on the next edge while idle.
    assign apply     = pending_q && (period_end || !enable);

    always_comb begin
        active_full_d = active_full_q;
        active_duty_d = active_duty_q;
        shadow_full_d = shadow_full_q;
        shadow_duty_d = shadow_duty_q;
        pending_d     = pending_q;
`ifdef PWM_CENTER_EN
        active_mode_d = active_mode_q;
        shadow_mode_d = shadow_mode_q;
`endif
        if (apply) begin
            active_full_d = shadow_full_q;
            active_duty_d = shadow_duty_q;
`ifdef PWM_CENTER_EN
            active_mode_d = shadow_mode_q;
`endif
            pending_d     = 1'b0;
        end
        if (handshake) begin
            shadow_full_d = cfg_full_cycle;
            shadow_duty_d = cfg_duty;
`ifdef PWM_CENTER_EN
            shadow_mode_d = pwm_mode_e'(cfg_mode);
`endif
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_full_q <= '0;
            active_duty_q <= '0;
            shadow_full_q <= '0;
            shadow_duty_q <= '0;
            pending_q     <= 1'b0;
`ifdef PWM_CENTER_EN
            active_mode_q <= PWM_EDGE;
            shadow_mode_q <= PWM_EDGE;
`endif
        end else begin
            active_full_q <= active_full_d;
            active_duty_q <= active_duty_d;
            shadow_full_q <= shadow_full_d;
            shadow_duty_q <= shadow_duty_d;
            pending_q     <= pending_d;
`ifdef PWM_CENTER_EN
            active_mode_q <= active_mode_d;
            shadow_mode_q <= shadow_mode_d;
`endif
        end
    end

    pwm_timebase #(.N(N)) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .full_cycle   (active_full_q),
`ifdef PWM_CENTER_EN
        .mode         (active_mode_q),
`endif
        .count        (count),
        .period_end   (period_end),
        .period_start (period_start)
    );

    // The counter never exceeds full_cycle, so duty above it saturates high.
    always_comb begin
        pwm_out = '0;
        for (int k = 0; k < CH; k++) begin
            pwm_out[k] = enable && (count < active_duty_q[k]);
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Randomized self-checking bench for pwm_bank (N=8, CH=2) against a period-position reference model.
module tb_pwm_bank;

    localparam int N  = 8;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [N-1:0]    cfg_full_cycle;
    logic [CH*N-1:0] cfg_duty;
    logic            cfg_mode;
    logic [CH-1:0]   pwm_out;
    logic            period_start;

    always #5 clk = ~clk;

    pwm_bank #(.N(N), .CH(CH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_full_cycle (cfg_full_cycle),
        .cfg_duty       (cfg_duty),
        .cfg_mode       (cfg_mode),
        .pwm_out        (pwm_out),
        .period_start   (period_start)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: active/shadow config plus the position inside the current period.
    int m_full, m_mode, m_pos;
    int m_duty[CH];
    int s_full, s_mode;
    int s_duty[CH];
    bit m_pending;

    function automatic bit is_center(int mode);
`ifdef PWM_CENTER_EN
        return mode != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int period_len();
        if (is_center(m_mode)) return (m_full == 0) ? 1 : 2 * m_full;
        return m_full + 1;
    endfunction

    function automatic int count_at(int p);
        if (is_center(m_mode) && p > m_full) return 2 * m_full - p;
        return p;
    endfunction

    function automatic void model_reset();
        m_full = 0; m_mode = 0; m_pos = 0; m_pending = 1'b0;
        s_full = 0; s_mode = 0;
        for (int k = 0; k < CH; k++) begin
            m_duty[k] = 0;
            s_duty[k] = 0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic en, input logic valid, input int full,
                                 input int d0, input int d1, input logic mode);
        logic [CH-1:0] exp_pwm;
        int  cnt;
        bit  hs, pe, ap;
        enable         = en;
        cfg_valid      = valid;
        cfg_full_cycle = N'(full);
        cfg_duty       = {N'(d1), N'(d0)};
        cfg_mode       = mode;
        @(negedge clk);
        cnt = count_at(m_pos);
        for (int k = 0; k < CH; k++) exp_pwm[k] = en && (cnt < m_duty[k]);
        checkOutput("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        checkOutput("period_start", 32'(period_start), 32'(en && (m_pos == 0)));
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
        @(posedge clk);
        hs = valid && !m_pending;
        pe = en && (m_pos == period_len() - 1);
        ap = m_pending && (pe || !en);
        m_pos = (en && !pe) ? m_pos + 1 : 0;
        if (ap) begin
            m_full = s_full; m_mode = s_mode; m_duty = s_duty; m_pending = 1'b0;
        end
        if (hs) begin
            s_full = full; s_mode = int'(mode); s_duty[0] = d0; s_duty[1] = d1; m_pending = 1'b1;
        end
        #1;
    endtask

    task automatic pulseReset(input logic en);
        enable    = en;
        cfg_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_pwm_out", 32'(pwm_out), 32'd0);
        checkOutput("rst_period_start", 32'(period_start), 32'd0);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic runIdle(input int cycles, input logic en);
        for (int i = 0; i < cycles; i++) applyStimulus(en, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_full_cycle = '0; cfg_duty = '0; cfg_mode = 1'b0;
        model_reset();
        pulseReset(1'b0);

        // Edge mode, full=9, duty {ch1=0, ch0=3}.
        applyStimulus(1'b1, 1'b1, 9, 3, 0, 1'b0);
        runIdle(35, 1'b1);

        // Duty change accepted mid-period at counter 4.
        for (int i = 0; i < 40 && count_at(m_pos) != 4; i++) runIdle(1, 1'b1);
        applyStimulus(1'b1, 1'b1, 9, 7, 0, 1'b0);
        runIdle(25, 1'b1);

        // Saturation above full_cycle, then a single-cycle period.
        applyStimulus(1'b1, 1'b1, 9, 12, 0, 1'b0);
        runIdle(25, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, 1, 0, 1'b0);
        runIdle(12, 1'b1);

        // Center-aligned request, full=4, duty=2 (edge behaviour when center mode is not built).
        applyStimulus(1'b1, 1'b1, 4, 2, 5, 1'b1);
        runIdle(30, 1'b1);
        applyStimulus(1'b1, 1'b1, 1, 1, 2, 1'b1);
        runIdle(10, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, 1, 0, 1'b1);
        runIdle(6, 1'b1);

        // Reset mid-period with a configuration pending.
        applyStimulus(1'b1, 1'b1, 9, 3, 0, 1'b0);
        runIdle(12, 1'b1);
        applyStimulus(1'b1, 1'b1, 6, 4, 6, 1'b0);
        pulseReset(1'b1);
        runIdle(10, 1'b1);

        // Configuration while idle, then enable.
        applyStimulus(1'b0, 1'b1, 9, 5, 2, 1'b0);
        runIdle(3, 1'b0);
        runIdle(25, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic en, v, md;
            int full, d0, d1;
            en   = ($urandom_range(0, 15) != 0);
            v    = ($urandom_range(0, 5) == 0);
            full = $urandom_range(0, 12);
            d0   = $urandom_range(0, 14);
            d1   = $urandom_range(0, 14);
            md   = 1'($urandom_range(0, 1));
            applyStimulus(en, v, full, d0, d1, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
